// File: rtl/spi_mem_reader.sv
// Read sequencer for the byte-level SPI controller: READ command, 24-bit address, N data bytes.
// Define SPI_MEM_FAST_READ_EN for FAST READ (0x0B) with one dummy byte after the address.
module spi_mem_reader (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [23:0] i_req_addr,
  input  logic [7:0]  i_req_len,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_valid,
  input  logic        i_rd_ready,
  output logic        o_busy,
  output logic        o_spi_start,
  output logic        o_spi_hold_n_ss,
  output logic [7:0]  o_spi_tx_byte,
  input  logic        i_spi_ready,
  input  logic [7:0]  i_spi_rx_byte
);

`ifdef SPI_MEM_FAST_READ_EN
  localparam logic [7:0] ReadCmd = 8'h0B;
`else
  localparam logic [7:0] ReadCmd = 8'h03;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr2,
    StAddr1,
    StAddr0,
    StData,
    StOut
`ifdef SPI_MEM_FAST_READ_EN
    ,
    StDummy
`endif
  } state_e;

  state_e      r_state, w_state_d;
  logic        r_issue, w_issue_d;
  logic [23:0] r_addr, w_addr_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic [7:0]  r_rd_data, w_rd_data_d;
  logic        r_rd_valid, w_rd_valid_d;
  logic        w_byte_phase;

  assign w_byte_phase = (r_state != StIdle) && (r_state != StOut);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_issue    <= 1'b0;
      r_addr     <= 24'h0;
      r_cnt      <= 8'h0;
      r_rd_data  <= 8'h0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_issue    <= w_issue_d;
      r_addr     <= w_addr_d;
      r_cnt      <= w_cnt_d;
      r_rd_data  <= w_rd_data_d;
      r_rd_valid <= w_rd_valid_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_issue_d    = r_issue;
    w_addr_d     = r_addr;
    w_cnt_d      = r_cnt;
    w_rd_data_d  = r_rd_data;
    w_rd_valid_d = r_rd_valid;
    case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_addr_d  = i_req_addr;
          w_cnt_d   = i_req_len;
          w_state_d = StCmd;
          w_issue_d = 1'b1;
        end
      end
      StOut: begin
        if (i_rd_ready) begin
          w_rd_valid_d = 1'b0;
          if (r_cnt == 8'h0) begin
            w_state_d = StIdle;
          end else begin
            w_cnt_d   = r_cnt - 8'h1;
            w_state_d = StData;
            w_issue_d = 1'b1;
          end
        end
      end
      default: begin
        // ISSUE lasts one cycle; WAIT ignores spi_ready until the controller has seen start.
        if (r_issue) begin
          w_issue_d = 1'b0;
        end else if (i_spi_ready) begin
          w_issue_d = 1'b1;
          case (r_state)
            StCmd:   w_state_d = StAddr2;
            StAddr2: w_state_d = StAddr1;
            StAddr1: w_state_d = StAddr0;
`ifdef SPI_MEM_FAST_READ_EN
            StAddr0: w_state_d = StDummy;
            StDummy: w_state_d = StData;
`else
            StAddr0: w_state_d = StData;
`endif
            StData: begin
              w_state_d    = StOut;
              w_issue_d    = 1'b0;
              w_rd_data_d  = i_spi_rx_byte;
              w_rd_valid_d = 1'b1;
            end
            default: begin
              w_state_d = StIdle;
              w_issue_d = 1'b0;
            end
          endcase
        end
      end
    endcase
  end

  always_comb begin
    o_spi_tx_byte   = 8'h00;
    o_spi_hold_n_ss = 1'b0;
    case (r_state)
      StCmd: begin
        o_spi_tx_byte   = ReadCmd;
        o_spi_hold_n_ss = 1'b1;
      end
      StAddr2: begin
        o_spi_tx_byte   = r_addr[23:16];
        o_spi_hold_n_ss = 1'b1;
      end
      StAddr1: begin
        o_spi_tx_byte   = r_addr[15:8];
        o_spi_hold_n_ss = 1'b1;
      end
      StAddr0: begin
        o_spi_tx_byte   = r_addr[7:0];
        o_spi_hold_n_ss = 1'b1;
      end
`ifdef SPI_MEM_FAST_READ_EN
      StDummy: o_spi_hold_n_ss = 1'b1;
`endif
      // Select is released only by the transfer of the last byte.
      StData:  o_spi_hold_n_ss = (r_cnt != 8'h0);
      StOut:   o_spi_hold_n_ss = (r_cnt != 8'h0);
      default: o_spi_hold_n_ss = 1'b0;
    endcase
  end

  assign o_spi_start = w_byte_phase & r_issue;
  assign o_req_ready = (r_state == StIdle);
  assign o_busy      = (r_state != StIdle);
  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_spi_mem_reader.sv
// Scoreboard bench for spi_mem_reader with a behavioural SPI controller model.
module tb_spi_mem_reader;

`ifdef SPI_MEM_FAST_READ_EN
  localparam logic [7:0] Cmd = 8'h0B;
  localparam int         Hdr = 5;
`else
  localparam logic [7:0] Cmd = 8'h03;
  localparam int         Hdr = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = 24'h0;
  logic [7:0]  req_len = 8'h0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b1;
  logic        busy;
  logic        spi_start;
  logic        spi_hold_n_ss;
  logic [7:0]  spi_tx_byte;
  logic        spi_ready = 1'b1;
  logic [7:0]  spi_rx_byte = 8'h0;

  always #5 clk = ~clk;

  spi_mem_reader dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_addr      (req_addr),
    .i_req_len       (req_len),
    .o_rd_data       (rd_data),
    .o_rd_valid      (rd_valid),
    .i_rd_ready      (rd_ready),
    .o_busy          (busy),
    .o_spi_start     (spi_start),
    .o_spi_hold_n_ss (spi_hold_n_ss),
    .o_spi_tx_byte   (spi_tx_byte),
    .i_spi_ready     (spi_ready),
    .i_spi_rx_byte   (spi_rx_byte)
  );

  logic [8:0] exp_tx_q[$];
  logic [7:0] rx_plan_q[$];
  logic [7:0] exp_rd_q[$];
  int checks = 0;
  int errors = 0;

  // Knobs owned by the main process
  int min_lat = 0;
  int max_lat = 1;
  bit rand_ready = 1'b0;
  int stall_idx = -1;

  // State owned by the controller/monitor process
  int lat_cnt = 0;
  bit pend_start = 1'b0;
  int stall_cnt = 0;
  int stalled_idx = -1;
  int rd_count = 0;
  int start_count = 0;
  bit held = 1'b0;
  logic [7:0] held_data = 8'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: what the controller must see and what the stream must deliver for one request.
  task automatic push_req(input logic [23:0] addr, input logic [7:0] len, input bit seq,
                          input logic [7:0] base);
    logic [7:0] d;
    exp_tx_q.push_back({1'b1, Cmd});
    exp_tx_q.push_back({1'b1, addr[23:16]});
    exp_tx_q.push_back({1'b1, addr[15:8]});
    exp_tx_q.push_back({1'b1, addr[7:0]});
    if (Hdr == 5) exp_tx_q.push_back({1'b1, 8'h00});
    for (int i = 0; i < Hdr; i++) rx_plan_q.push_back(8'($urandom));
    for (int i = 0; i <= int'(len); i++) begin
      d = seq ? 8'(int'(base) + i) : 8'($urandom);
      exp_tx_q.push_back({(i != int'(len)), 8'h00});
      rx_plan_q.push_back(d);
      exp_rd_q.push_back(d);
    end
  endtask

  task automatic do_req(input logic [23:0] addr, input logic [7:0] len, input bit seq,
                        input logic [7:0] base);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    push_req(addr, len, seq, base);
    #2;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 24'h0;
    req_len   = 8'h0;
    #2;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      #3;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({name, "_rd_left"}, 32'(exp_rd_q.size()), 32'd0);
    chk({name, "_tx_left"}, 32'(exp_tx_q.size()), 32'd0);
  endtask

  // Controller model and monitors: inputs updated at negedge, handshakes judged 1 unit later.
  always @(negedge clk) begin
    logic [8:0] e;
    logic [7:0] r;
    if (!rst) begin
      if (pend_start) begin
        spi_ready  = 1'b0;
        lat_cnt    = int'($urandom_range(max_lat, min_lat));
        pend_start = 1'b0;
      end else if (!spi_ready) begin
        if (lat_cnt == 0) begin
          spi_ready = 1'b1;
          if (rx_plan_q.size() == 0) begin
            spi_rx_byte = 8'hEE;
            chk("rx_plan_nonempty", 32'd0, 32'd1);
          end else begin
            spi_rx_byte = rx_plan_q.pop_front();
          end
        end else begin
          lat_cnt--;
        end
      end
      if (rd_valid && rd_count == stall_idx && stalled_idx != stall_idx) begin
        stall_cnt   = 20;
        stalled_idx = stall_idx;
      end
      if (stall_cnt > 0) begin
        rd_ready = 1'b0;
        stall_cnt--;
      end else begin
        rd_ready = rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
      end
    end
    #1;
    if (rst) begin
      exp_tx_q.delete();
      rx_plan_q.delete();
      exp_rd_q.delete();
      spi_ready  = 1'b1;
      pend_start = 1'b0;
      lat_cnt    = 0;
      stall_cnt  = 0;
      held       = 1'b0;
      rd_ready   = 1'b1;
    end else begin
      if (spi_start) begin
        chk("start_when_ready", 32'(spi_ready), 32'd1);
        chk("start_no_pending_rd", 32'(rd_valid), 32'd0);
        if (exp_tx_q.size() == 0) begin
          chk("unexpected_start", 32'(spi_tx_byte), 32'h100);
        end else begin
          e = exp_tx_q.pop_front();
          chk("tx_byte", 32'(spi_tx_byte), 32'(e[7:0]));
          chk("hold_n_ss", 32'(spi_hold_n_ss), 32'(e[8]));
        end
        pend_start = 1'b1;
        start_count++;
      end
      if (rd_valid) begin
        if (held) chk("rd_data_stable", 32'(rd_data), 32'(held_data));
        if (rd_ready) begin
          if (exp_rd_q.size() == 0) begin
            chk("unexpected_rd", 32'(rd_data), 32'h100);
          end else begin
            r = exp_rd_q.pop_front();
            chk("rd_data", 32'(rd_data), 32'(r));
          end
          rd_count++;
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_data = rd_data;
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    bit hit;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_spi_start", 32'(spi_start), 32'd0);
    chk("rst_hold", 32'(spi_hold_n_ss), 32'd0);
    chk("rst_tx", 32'(spi_tx_byte), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Single byte
    do_req(24'h123456, 8'd0, 1'b1, 8'hA5);
    wait_idle("single");

    // Four-byte burst
    max_lat = 3;
    do_req(24'h00ABCD, 8'd3, 1'b1, 8'h10);
    wait_idle("burst");

    // Backpressure on byte 2 of 4
    stall_idx = rd_count + 1;
    do_req(24'h765432, 8'd3, 1'b0, 8'h00);
    wait_idle("stall");
    stall_idx = -1;

    // Request while busy must be ignored
    do_req(24'h111111, 8'd3, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_addr  = 24'hABCDEF;
      req_len   = 8'd9;
      #2;
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    wait_idle("busy_req");

    // Reset during ADDR1 WAIT
    min_lat = 3;
    max_lat = 5;
    s0 = start_count;
    do_req(24'h0F0E0D, 8'd2, 1'b0, 8'h00);
    hit = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (start_count >= s0 + 3) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
      #3;
    end
    chk("reach_addr1", 32'(hit), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_start", 32'(spi_start), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    min_lat = 0;
    max_lat = 2;
    do_req(24'h000100, 8'd0, 1'b0, 8'h00);
    wait_idle("after_rst");

    // Randomized traffic, including the 256-byte boundary
    rand_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      max_lat = int'($urandom_range(4, 0));
      do_req(24'($urandom), 8'($urandom_range(12, 0)), 1'b0, 8'h00);
      wait_idle("rand");
    end
    do_req(24'hFFFFFF, 8'd255, 1'b0, 8'h00);
    wait_idle("len256");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_reader.md
# spi_mem_reader

Read sequencer that sits directly upstream of the byte-level SPI controller. It accepts a read request (24-bit address, byte count), then drives the controller's `start`/`tx_byte`/`hold_n_ss` handshake to send a READ command, three address bytes and N dummy-clocked data bytes. Received bytes are delivered downstream on a valid/ready stream. Chip select stays asserted across the whole burst and is released only after the last data byte.

## Interface
- No parameters.
- `clk`  in  1  clock; everything synchronous to rising edge.
- `rst`  in  1  synchronous reset, active high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; request accepted when `req_valid & req_ready`.
- `req_addr`  in  24  start byte address (sent MSB byte first).
- `req_len`  in  8  byte count minus one (0 → 1 byte, 255 → 256 bytes).
- `rd_data`  out  8  received byte (registered).
- `rd_valid`  out  1  `rd_data` valid; held until `rd_ready`.
- `rd_ready`  in  1  downstream accepts byte.
- `busy`  out  1  high from request acceptance until return to IDLE.
- `spi_start`  out  1  to controller `start`; one-cycle pulse.
- `spi_hold_n_ss`  out  1  to controller `hold_n_ss`.
- `spi_tx_byte`  out  8  to controller `tx_byte`.
- `spi_ready`  in  1  from controller `ready`.
- `spi_rx_byte`  in  8  from controller `rx_byte`.

## Operation
- States: IDLE, CMD, ADDR2, ADDR1, ADDR0, [DUMMY], DATA, OUT.
- Every byte phase has two sub-steps: ISSUE (one cycle, `spi_start`=1, entered only when `spi_ready`=1) then WAIT (until `spi_ready`=1). `spi_tx_byte` and `spi_hold_n_ss` are stable throughout ISSUE.
- IDLE: `req_ready`=1. On accept, latch addr/len into internal registers, byte counter ← `req_len`, go to CMD.
- CMD sends 0x03; ADDR2/1/0 send addr[23:16], [15:8], [7:0]. `spi_hold_n_ss`=1.
- DATA sends 0x00. `spi_hold_n_ss`=1 unless counter = 0 (last byte), then 0.
- On DATA WAIT completion: `rd_data` ← `spi_rx_byte`, `rd_valid` ← 1, go to OUT.
- OUT: wait for `rd_ready`. On handshake, `rd_valid` ← 0. If counter = 0 go to IDLE, else counter − 1 and go to DATA. No SPI transfer is started while `rd_valid`=1, so SCLK stalls under backpressure with select held.
- Requests while not IDLE are not accepted (`req_ready`=0). Request inputs are ignored after acceptance.
- Reset values: `req_ready`=1 after the reset cycle; `busy`=0, `rd_valid`=0, `rd_data`=0x00, `spi_start`=0, `spi_hold_n_ss`=0, `spi_tx_byte`=0x00. State IDLE, counter 0.
- Reset mid-burst: return to IDLE immediately and drop any pending `rd_valid`. `rst` is shared with the controller, so select deasserts via its reset.

## Timing
- `spi_start` is combinational from state==ISSUE. ISSUE always lasts exactly one cycle.
- Because the controller's `ready` falls the cycle after `start`, WAIT must not sample `spi_ready` in the ISSUE cycle.
- WAIT completes on the first cycle `spi_ready`=1. That cycle `spi_rx_byte` is valid.
- `rd_valid` rises 1 cycle after DATA WAIT completion.
- Next ISSUE is no earlier than 1 cycle after the `rd_ready` handshake.
- Request accept → first `spi_start`: 1 cycle.
- `busy` falls the cycle after the final OUT handshake.

## Configuration
- `SPI_MEM_FAST_READ_EN` defined:
  - CMD sends 0x0B instead of 0x03.
  - DUMMY state (one 0x00 transfer, `spi_hold_n_ss`=1, result discarded) is inserted between ADDR0 and DATA.
- Not defined: DUMMY state and its logic are absent; the command is 0x03.

## Test plan
- Single byte: addr 0x123456, len 0, model returns 0xA5 → controller sees tx bytes 0x03,0x12,0x34,0x56,0x00. `hold_n_ss` = 1,1,1,1,0. One `rd_valid` with 0xA5. `busy` low afterwards.
- Burst: len 3, model returns 0x10..0x13 → four outputs in order. Select never deasserts between bytes; `hold_n_ss`=0 only on the fourth data transfer.
- Backpressure: `rd_ready` low 20 cycles on byte 2 of 4 → `rd_data` stable, no `spi_start` during stall, stream resumes correctly.
- Request while busy: `req_valid` pulsed mid-burst with other addr → ignored, `req_ready`=0, original burst unaffected.
- Reset mid-burst: `rst` during ADDR1 WAIT → next cycle IDLE, `rd_valid`=0, `spi_start`=0; a new request then completes normally.
- With `SPI_MEM_FAST_READ_EN`: addr 0x000100, len 0 → tx bytes 0x0B,0x00,0x01,0x00,0x00,0x00. Only the sixth transfer's rx byte is emitted.
